// File: rtl/mem_copy_engine.sv
// Block-move master for the data memory: copies len bytes src->dst,
// overlap-safe (descending when dst lies inside the source window).
// Ports: clk, reset (sync, active-high); start/src/dst/len request;
// mem_addr/mem_wr_en/mem_dat_out/mem_dat_in memory port;
// busy, done (1-cycle pulse), checksum (sum mod 2**DW of bytes moved).
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_out,
  input  logic [DW-1:0] mem_dat_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          desc_q, desc_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] csum_q, csum_d;
  logic [AW-1:0] diff;

  assign diff = dst - src;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rem_d    = rem_q;
    desc_d   = desc_q;
    data_d   = data_q;
    csum_d   = csum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Copy from the top down when dst starts inside the
          // source window, so no source byte is overwritten early.
          desc_d   = (diff != '0) && (diff < len);
          rd_ptr_d = desc_d ? src + len - ONE : src;
          wr_ptr_d = desc_d ? dst + len - ONE : dst;
          rem_d    = len;
          csum_d   = '0;
          state_d  = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        data_d   = mem_dat_in;
        csum_d   = csum_q + mem_dat_in;
        rd_ptr_d = desc_q ? rd_ptr_q - ONE : rd_ptr_q + ONE;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        wr_ptr_d = desc_q ? wr_ptr_q - ONE : wr_ptr_q + ONE;
        rem_d    = rem_q - ONE;
        state_d  = (rem_q == ONE) ? S_DONE : S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rem_q    <= '0;
      desc_q   <= 1'b0;
      data_q   <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rem_q    <= rem_d;
      desc_q   <= desc_d;
      data_q   <= data_d;
      csum_q   <= csum_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    unique case (state_q)
      S_READ:  mem_addr = rd_ptr_q;
      S_WRITE: mem_addr = wr_ptr_q;
      default: mem_addr = '0;
    endcase
  end

  assign mem_wr_en   = (state_q == S_WRITE);
  assign busy        = (state_q == S_READ) || (state_q == S_WRITE);
  assign done        = (state_q == S_DONE);
  assign mem_dat_out = data_q;
  assign checksum    = csum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 256x8 behavioural memory.
// Checks copies, overlap order, wrap, len=0, busy-start and reset abort.
module tb_mem_copy_engine;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] src, dst, len;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_dat_out;
  logic [7:0] mem_dat_in;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_dat_out (mem_dat_out),
    .mem_dat_in  (mem_dat_in),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  logic [7:0] mem [0:255];
  logic [7:0] waddr [0:1023];
  int         wr_cnt;
  logic       tb_we;
  logic [7:0] tb_addr, tb_dat;

  assign mem_dat_in = mem[mem_addr];

  initial wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr]  <= mem_dat_out;
      waddr[wr_cnt[9:0]] <= mem_addr;
      wr_cnt         <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_dat;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_addr = a;
    tb_dat  = d;
    tb_we   = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  int w0;

  task automatic run(input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] l, input bit extra,
                     output int lat, output int dn, output int wr);
    int cyc;
    w0 = wr_cnt;
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src = 8'h5A; dst = 8'hA5; len = 8'h77;
    cyc = 1; lat = 0; dn = 0;
    while (cyc < 300) begin
      if (done) begin
        dn++;
        if (lat == 0) lat = cyc;
      end
      if (extra && cyc == 3) begin
        src = 8'h00; dst = 8'h90; len = 8'h05; start = 1'b1;
      end
      if (extra && cyc == 4) start = 1'b0;
      if (lat != 0 && cyc >= lat + 4) break;
      @(negedge clk);
      cyc++;
    end
    if (lat == 0) chk("done_timeout", 0, 1);
    wr = wr_cnt - w0;
  endtask

  int lat, dn, wr;

  initial begin
    tb_we = 1'b0; tb_addr = '0; tb_dat = '0;
    reset = 1'b1; start = 1'b1;
    src = 8'h10; dst = 8'h40; len = 8'h04;
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_wr_en, 0);
    chk("rst_dout", mem_dat_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_csum", checksum, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_reset_ignored", busy, 0);

    poke(8'h10, 8'h11); poke(8'h11, 8'h22);
    poke(8'h12, 8'h33); poke(8'h13, 8'h44);
    run(8'h10, 8'h40, 8'h04, 0, lat, dn, wr);
    chk("asc_lat", lat, 9);
    chk("asc_writes", wr, 4);
    chk("asc_csum", checksum, 8'hAA);
    chk("asc_first_wa", waddr[w0], 8'h40);
    chk("asc_d0", mem[8'h40], 8'h11);
    chk("asc_d3", mem[8'h43], 8'h44);
    chk("asc_src_kept", mem[8'h12], 8'h33);

    poke(8'h20, 8'h01); poke(8'h21, 8'h02);
    poke(8'h22, 8'h03); poke(8'h23, 8'h04);
    run(8'h20, 8'h22, 8'h04, 0, lat, dn, wr);
    chk("ovu_first_wa", waddr[w0], 8'h25);
    chk("ovu_csum", checksum, 8'h0A);
    chk("ovu_d22", mem[8'h22], 8'h01);
    chk("ovu_d23", mem[8'h23], 8'h02);
    chk("ovu_d24", mem[8'h24], 8'h03);
    chk("ovu_d25", mem[8'h25], 8'h04);

    poke(8'h22, 8'h0A); poke(8'h23, 8'h0B);
    poke(8'h24, 8'h0C); poke(8'h25, 8'h0D);
    run(8'h22, 8'h20, 8'h04, 0, lat, dn, wr);
    chk("ovd_first_wa", waddr[w0], 8'h20);
    chk("ovd_last_wa", waddr[w0 + 3], 8'h23);
    chk("ovd_csum", checksum, 8'h2E);
    chk("ovd_d20", mem[8'h20], 8'h0A);
    chk("ovd_d23", mem[8'h23], 8'h0D);

    poke(8'hFE, 8'h5A); poke(8'hFF, 8'h6B); poke(8'h00, 8'h7C);
    run(8'hFE, 8'h80, 8'h03, 0, lat, dn, wr);
    chk("wrap_writes", wr, 3);
    chk("wrap_csum", checksum, 8'h41);
    chk("wrap_d80", mem[8'h80], 8'h5A);
    chk("wrap_d82", mem[8'h82], 8'h7C);

    run(8'h10, 8'h50, 8'h00, 0, lat, dn, wr);
    chk("len0_lat", lat, 1);
    chk("len0_writes", wr, 0);
    chk("len0_csum", checksum, 0);

    run(8'h10, 8'hA0, 8'h03, 1, lat, dn, wr);
    chk("busy_start_writes", wr, 3);
    chk("busy_start_dones", dn, 1);
    chk("busy_start_lat", lat, 7);
    chk("busy_start_csum", checksum, 8'h66);

    poke(8'h62, 8'hEE);
    w0 = wr_cnt;
    @(negedge clk);
    src = 8'h10; dst = 8'h60; len = 8'h04; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_write", mem_wr_en, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_addr", mem_addr, 0);
    chk("abort_we", mem_wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_dout", mem_dat_out, 0);
    chk("abort_csum", checksum, 0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_writes", wr_cnt - w0, 2);
    chk("abort_d61", mem[8'h61], 8'h22);
    chk("abort_d62", mem[8'h62], 8'hEE);

    run(8'h10, 8'h70, 8'h02, 0, lat, dn, wr);
    chk("post_lat", lat, 5);
    chk("post_csum", checksum, 8'h33);
    chk("post_d71", mem[8'h71], 8'h22);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
